// File: rtl/digit_conv_arb.sv
// digit_conv_arb: two-requester round-robin front end feeding a sequential
// binary-to-digit converter. One base-BASE digit is produced per clock by
// repeated divide/modulo; the packed digits, leading-zero blank mask and
// overflow flag are published together with a one-cycle done pulse.
module digit_conv_arb #(
    parameter int W_IN   = 14,
    parameter int DIGITS = 4,
    parameter int BASE   = 10
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [1:0]            req,
    input  logic [W_IN-1:0]       val0,
    input  logic [W_IN-1:0]       val1,
    output logic [1:0]            ack,
    output logic                  busy,
    output logic                  done,
    output logic                  done_id,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     blank,
    output logic                  ovf
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [W_IN-1:0]   BASE_W    = W_IN'(BASE);
    localparam logic [CW-1:0]     CNT_LAST  = CW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    logic [1:0]          state_q,   state_d;
    logic                ptr_q,     ptr_d;
    logic [W_IN-1:0]     rem_q,     rem_d;
    logic [CW-1:0]       cnt_q,     cnt_d;
    logic [4*DIGITS-1:0] work_q,    work_d;
    logic                id_q,      id_d;
    logic [1:0]          ack_q,     ack_d;
    logic                done_q,    done_d;
    logic                done_id_q, done_id_d;
    logic [4*DIGITS-1:0] digits_q,  digits_d;
    logic [DIGITS-1:0]   blank_q,   blank_d;
    logic                ovf_q,     ovf_d;

    logic                win;
    logic [W_IN-1:0]     quot;
    logic [3:0]          digit;
    logic [4*DIGITS-1:0] work_nx;
    logic [DIGITS-1:0]   blank_nx;

    // Constant-divisor divide/modulo of the running remainder, plus the
    // working register with the current digit slot replaced.
    always_comb begin
        quot    = rem_q / BASE_W;
        digit   = 4'(rem_q % BASE_W);
        work_nx = work_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (cnt_q == CW'(i)) work_nx[4*i +: 4] = digit;
        end
    end

    // Blank mask from the final digits: scan downward from the top digit,
    // staying blank while every digit seen so far is zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        blank_nx = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            zero_run = zero_run & (work_nx[4*(DIGITS-1-k) +: 4] == 4'd0);
            blank_nx[DIGITS-1-k] = zero_run;
        end
        blank_nx[0] = 1'b0;
    end

    // Next-state logic: arbitration and capture in IDLE, one digit per
    // cycle in CONV, atomic result publish on the last CONV edge.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        id_d      = id_q;
        ack_d     = '0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        digits_d  = digits_q;
        blank_d   = blank_q;
        ovf_d     = ovf_q;
        win       = (req == 2'b11) ? ptr_q : req[1];
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    rem_d   = win ? val1 : val0;
                    cnt_d   = '0;
                    work_d  = '0;
                    id_d    = win;
                    ptr_d   = ~win;
                    ack_d   = win ? 2'b10 : 2'b01;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                work_d = work_nx;
                rem_d  = quot;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    digits_d  = work_nx;
                    blank_d   = blank_nx;
                    ovf_d     = (quot != '0);
                    done_id_d = id_q;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            ptr_q     <= 1'b0;
            rem_q     <= '0;
            cnt_q     <= '0;
            work_q    <= '0;
            id_q      <= 1'b0;
            ack_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            digits_q  <= '0;
            blank_q   <= BLANK_RST;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            id_q      <= id_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            digits_q  <= digits_d;
            blank_q   <= blank_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ack     = ack_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign done_id = done_id_q;
    assign digits  = digits_q;
    assign blank   = blank_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_digit_conv_arb.sv
// Directed bench for digit_conv_arb: decimal instance for the main function,
// arbitration and reset abort; a BASE=16 instance for the hex radix case.
module tb_digit_conv_arb;

    logic        clk = 1'b0;
    logic        nrst;
    logic [1:0]  req;
    logic [13:0] val0, val1;
    logic [1:0]  ack;
    logic        busy, done, done_id, ovf;
    logic [15:0] digits;
    logic [3:0]  blank;

    logic [1:0]  req_h;
    logic [13:0] val0_h, val1_h;
    logic [1:0]  ack_h;
    logic        busy_h, done_h, done_id_h, ovf_h;
    logic [15:0] digits_h;
    logic [3:0]  blank_h;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    digit_conv_arb #(.W_IN(14), .DIGITS(4), .BASE(10)) dut (
        .clk(clk), .nrst(nrst), .req(req), .val0(val0), .val1(val1),
        .ack(ack), .busy(busy), .done(done), .done_id(done_id),
        .digits(digits), .blank(blank), .ovf(ovf)
    );

    digit_conv_arb #(.W_IN(14), .DIGITS(4), .BASE(16)) dut_hex (
        .clk(clk), .nrst(nrst), .req(req_h), .val0(val0_h), .val1(val1_h),
        .ack(ack_h), .busy(busy_h), .done(done_h), .done_id(done_id_h),
        .digits(digits_h), .blank(blank_h), .ovf(ovf_h)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for done on the decimal instance; returns cycles waited.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 20);
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_one(input string tag, input bit id, input logic [13:0] v,
                           input logic [15:0] exp_d, input logic [3:0] exp_b,
                           input logic exp_o);
        int n;
        if (id) val1 = v; else val0 = v;
        req = id ? 2'b10 : 2'b01;
        tick();
        check({tag, "_ack"}, 32'(ack), id ? 32'd2 : 32'd1);
        req  = 2'b00;
        val0 = 14'h1555;   // post-capture changes must not matter
        val1 = 14'h2AAA;
        wait_done(n);
        check({tag, "_lat"}, 32'(n), 32'd4);
        check({tag, "_digits"}, 32'(digits), 32'(exp_d));
        check({tag, "_blank"}, 32'(blank), 32'(exp_b));
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_o));
        check({tag, "_id"}, 32'(done_id), 32'(id));
        tick();
        check({tag, "_done_clr"}, {busy, done, digits}, {2'b00, exp_d});
    endtask

    initial begin
        int n;
        logic saw_done;
        nrst = 1'b0; req = 2'b00; val0 = '0; val1 = '0;
        req_h = 2'b00; val0_h = '0; val1_h = '0;
        #12;
        check("rst_outs", {ack, busy, done, done_id, ovf}, 32'd0);
        check("rst_digits", 32'(digits), 32'd0);
        check("rst_blank", 32'(blank), 32'hE);
        nrst = 1'b1;
        tick();

        run_one("single",  1'b0, 14'd1234,  16'h1234, 4'b0000, 1'b0);
        run_one("lz7",     1'b1, 14'd7,     16'h0007, 4'b1110, 1'b0);
        run_one("zero",    1'b0, 14'd0,     16'h0000, 4'b1110, 1'b0);
        run_one("ovf",     1'b0, 14'd12345, 16'h2345, 4'b0000, 1'b1);
        run_one("max9999", 1'b0, 14'd9999,  16'h9999, 4'b0000, 1'b0);

        // Arbitration: both requests held from reset.
        nrst = 1'b0; req = 2'b11; val0 = 14'd11; val1 = 14'd22;
        tick();
        nrst = 1'b1;
        wait_done(n);
        for (int k = 0; k < 4; k++) begin
            check("arb_id", 32'(done_id), 32'(k % 2));
            check("arb_digits", 32'(digits), (k % 2) ? 32'h0022 : 32'h0011);
            check("arb_blank", 32'(blank), 32'hC);
            if (k < 3) begin
                wait_done(n);
                check("arb_gap", 32'(n), 32'd6);
            end
        end
        req = 2'b00;
        tick();
        tick();

        // Reset mid-conversion.
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        val0 = 14'd1234; val1 = 14'd4321;
        req = 2'b11;
        tick();
        check("abort_ack", 32'(ack), 32'd1);
        req = 2'b00;
        tick();
        tick();
        nrst = 1'b0;
        #1;
        check("abort_outs", {ack, busy, done, done_id, ovf}, 32'd0);
        check("abort_digits", 32'(digits), 32'd0);
        check("abort_blank", 32'(blank), 32'hE);
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            saw_done = saw_done | done;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        nrst = 1'b1;
        req = 2'b11;
        tick();
        check("post_rst_ack", 32'(ack), 32'd1);
        req = 2'b00;
        wait_done(n);
        check("post_rst_id", 32'(done_id), 32'd0);
        check("post_rst_digits", 32'(digits), 32'h1234);
        tick();

        // Hexadecimal radix instance.
        val0_h = 14'h3A7;
        req_h = 2'b01;
        tick();
        check("hex_ack", 32'(ack_h), 32'd1);
        req_h = 2'b00;
        n = 0;
        do begin
            tick();
            n++;
        end while (!done_h && n < 20);
        check("hex_lat", 32'(n), 32'd4);
        check("hex_digits", 32'(digits_h), 32'h03A7);
        check("hex_blank", 32'(blank_h), 32'h8);
        check("hex_ovf", 32'(ovf_h), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
